// File: rtl/snd_pkg.sv
// Shared state encoding, default timing constants and a width helper for the
// button-driven voice scheduler.
package snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } snd_state_e;

  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_DUR_MS   = 250;
  localparam int DEF_GAP_MS   = 20;
  localparam int DEF_ACK_TMO  = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snd_voice_sched_rr_arbiter.sv
// Round-robin grant: picks the first set request at or after last+1,
// wrapping modulo N_REQ.
module rr_arbiter
  import snd_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id
);

  int idx;

  // Scanning from the farthest candidate down lets the nearest one win.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/snd_voice_sched.sv
// Voice scheduler: latches button requests, grants them round-robin and
// sequences the sound engine through start, timed play and a silent gap.
module snd_voice_sched
  import snd_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int DUR_MS   = DEF_DUR_MS,
  parameter int GAP_MS   = DEF_GAP_MS,
  parameter int ACK_TMO  = DEF_ACK_TMO,
  localparam int IW      = idx_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] btn,
  input  logic             low_batt,
  input  logic             snd_busy,
  output logic             snd_start,
  output logic             snd_stop,
  output logic [IW-1:0]    snd_id,
  output logic             snd_slow,
  output logic [N_REQ-1:0] pending,
  output logic             active
);

  // state    | meaning
  // ST_IDLE  | waiting for a pending request to grant
  // ST_START | start pulse issued, waiting for engine busy (bounded)
  // ST_PLAY  | sound playing, duration timer running in ms ticks
  // ST_GAP   | enforced silence before the next grant

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DMAX = (2 * DUR_MS > GAP_MS) ? 2 * DUR_MS : GAP_MS;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int AW   = $clog2(ACK_TMO + 1);

  snd_state_e       state_q;
  logic             snd_start_q, snd_stop_q, snd_slow_q, active_q;
  logic [IW-1:0]    snd_id_q, last_id_q;
  logic [DW-1:0]    tmr_q;
  logic [AW-1:0]    ack_q;
  logic [TW-1:0]    tick_cnt_q;
  logic [N_REQ-1:0] btn_s1_q, btn_s2_q, btn_s3_q;
  logic [N_REQ-1:0] pending_q, pending_d;

  logic             tick;
  logic [N_REQ-1:0] btn_rise, own_mask, grant_mask;
  logic             restart, grant_valid, grant_fire;
  logic [IW-1:0]    grant_id;
  logic [DW-1:0]    dur_last;

  assign tick     = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign btn_rise = btn_s2_q & ~btn_s3_q;
  assign dur_last = snd_slow_q ? DW'(2 * DUR_MS - 1) : DW'(DUR_MS - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_s3_q   <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      btn_s1_q   <= btn;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
    end
  end

  rr_arbiter #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_arb (
    .req        (pending_q),
    .last       (last_id_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign grant_fire = (state_q == ST_IDLE) && grant_valid;

  // A press of the button that owns the playing sound retriggers it instead
  // of queueing; a press landing in its own grant cycle is absorbed.
  always_comb begin
    own_mask   = '0;
    grant_mask = '0;
    if (state_q == ST_PLAY) own_mask[snd_id_q] = 1'b1;
    if (grant_fire) grant_mask[grant_id] = 1'b1;
    pending_d = (pending_q | (btn_rise & ~own_mask)) & ~grant_mask;
  end

  assign restart = |(btn_rise & own_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      snd_start_q <= 1'b0;
      snd_stop_q  <= 1'b0;
      snd_id_q    <= '0;
      snd_slow_q  <= 1'b0;
      active_q    <= 1'b0;
      last_id_q   <= IW'(N_REQ - 1);
      tmr_q       <= '0;
      ack_q       <= '0;
    end else begin
      snd_start_q <= 1'b0;
      snd_stop_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q     <= ST_START;
            snd_start_q <= 1'b1;
            snd_id_q    <= grant_id;
            last_id_q   <= grant_id;
            snd_slow_q  <= low_batt;
            active_q    <= 1'b1;
            ack_q       <= '0;
          end
        end
        ST_START: begin
          if (snd_busy) begin
            state_q <= ST_PLAY;
            tmr_q   <= '0;
          end else if (ack_q == AW'(ACK_TMO - 1)) begin
            state_q  <= ST_GAP;
            active_q <= 1'b0;
            tmr_q    <= '0;
          end else begin
            ack_q <= ack_q + AW'(1);
          end
        end
        ST_PLAY: begin
          if (!snd_busy) begin
            state_q  <= ST_GAP;
            active_q <= 1'b0;
            tmr_q    <= '0;
          end else if (restart) begin
            tmr_q <= '0;
          end else if (tick) begin
            if (tmr_q == dur_last) begin
              snd_stop_q <= 1'b1;
              state_q    <= ST_GAP;
              active_q   <= 1'b0;
              tmr_q      <= '0;
            end else begin
              tmr_q <= tmr_q + DW'(1);
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (tmr_q == DW'(GAP_MS - 1)) begin
              state_q <= ST_IDLE;
              tmr_q   <= '0;
            end else begin
              tmr_q <= tmr_q + DW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign snd_start = snd_start_q;
  assign snd_stop  = snd_stop_q;
  assign snd_id    = snd_id_q;
  assign snd_slow  = snd_slow_q;
  assign pending   = pending_q;
  assign active    = active_q;

endmodule

// File: tb/tb_snd_voice_sched.sv
// Scoreboard bench for snd_voice_sched: stimulus pushes expected start/end
// events with cycle stamps, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_snd_voice_sched;

  localparam int N    = 8;
  localparam int TD   = 10;
  localparam int DUR  = 250;
  localparam int GAPT = 20;
  localparam int ACKT = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] btn = '0;
  logic         low_batt = 1'b0;
  logic         snd_busy = 1'b0;
  logic         snd_start, snd_stop, snd_slow, active;
  logic [2:0]   snd_id;
  logic [N-1:0] pending;

  snd_voice_sched #(
    .N_REQ(N), .TICK_DIV(TD), .DUR_MS(DUR), .GAP_MS(GAPT), .ACK_TMO(ACKT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn),
    .low_batt (low_batt),
    .snd_busy (snd_busy),
    .snd_start(snd_start),
    .snd_stop (snd_stop),
    .snd_id   (snd_id),
    .snd_slow (snd_slow),
    .pending  (pending),
    .active   (active)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; equals the DUT tick counter phase.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    bit is_end;
    int id;
    bit slow;
    bit stop;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_pass = 0;
  int  n_total = 0;
  bit  engine_en = 1'b1;
  int  busy_dly = 0;
  logic active_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic unexpected(input string name);
    n_total++;
    $display("FAIL %s: DUT event at cycle %0d, none expected", name, cyc);
  endtask

  function automatic int tick_after(input int t);
    int u;
    u = t;
    while (u % TD != TD - 1) u++;
    return u;
  endfunction

  task automatic push_start(input int id, input bit slow, input int s);
    ev_t e;
    e = '{1'b0, id, slow, 1'b0, s};
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int id, input bit stop, input int c);
    ev_t e;
    e = '{1'b1, id, 1'b0, stop, c};
    exp_q.push_back(e);
  endtask

  // Normal play: busy rises 2 cycles after start, PLAY begins at start+3.
  task automatic push_play(input int id, input bit slow, input int s,
                           input int lim, output int nxt);
    int stopv;
    push_start(id, slow, s);
    stopv = tick_after(s + 3) + (lim - 1) * TD + 1;
    push_end(id, 1'b1, stopv);
    nxt = tick_after(stopv) + (GAPT - 1) * TD + 2;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_press(input logic [N-1:0] m, output int x);
    btn = btn | m;
    x = cyc;
  endtask

  task automatic do_release(input logic [N-1:0] m);
    repeat (4) @(negedge clk);
    btn = btn & ~m;
  endtask

  // Sound engine model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        snd_busy = 1'b0;
        busy_dly = 0;
      end else begin
        if (busy_dly > 0) begin
          busy_dly--;
          if (busy_dly == 0) snd_busy = 1'b1;
        end
        if (snd_start && engine_en) busy_dly = 2;
        if (snd_stop) snd_busy = 1'b0;
      end
    end
  end

  // Monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (snd_start) begin
          if (exp_q.size() == 0 || exp_q[0].is_end) unexpected("start_event");
          else begin
            mon_e = exp_q.pop_front();
            check("start_id", int'(snd_id), mon_e.id);
            check("start_slow", int'(snd_slow), int'(mon_e.slow));
            check("start_cycle", cyc, mon_e.cyc);
            check("start_active", int'(active), 1);
          end
        end
        if (active_prev && !active) begin
          if (exp_q.size() == 0 || !exp_q[0].is_end) unexpected("end_event");
          else begin
            mon_e = exp_q.pop_front();
            check("end_cycle", cyc, mon_e.cyc);
            check("end_stop", int'(snd_stop), int'(mon_e.stop));
            check("end_id", int'(snd_id), mon_e.id);
          end
        end else if (snd_stop) begin
          unexpected("stray_stop");
        end
      end
      active_prev = reset_n ? active : 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int x, s, s2, n1, n2, n3, t0, x2, stopv;

    repeat (3) @(negedge clk);
    check("rst_start", int'(snd_start), 0);
    check("rst_stop", int'(snd_stop), 0);
    check("rst_id", int'(snd_id), 0);
    check("rst_slow", int'(snd_slow), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_active", int'(active), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single request on id 3.
    do_press(8'h08, x);
    s = x + 4;
    push_play(3, 1'b0, s, DUR, n1);
    do_release(8'h08);
    wait_until(s + 50);
    check("t1_active_play", int'(active), 1);
    check("t1_id_hold", int'(snd_id), 3);
    check("t1_pending", int'(pending), 0);
    wait_until(n1 + 5);

    // Engine never acknowledges.
    engine_en = 1'b0;
    do_press(8'h20, x);
    s = x + 4;
    push_start(5, 1'b0, s);
    push_end(5, 1'b0, s + ACKT);
    n1 = tick_after(s + ACKT) + (GAPT - 1) * TD + 2;
    do_release(8'h20);
    wait_until(n1 + 5);
    engine_en = 1'b1;

    // Three simultaneous requests after last_id=5.
    do_press(8'h62, x);
    s = x + 4;
    push_play(6, 1'b0, s, DUR, n1);
    push_play(1, 1'b0, n1, DUR, n2);
    push_play(5, 1'b0, n2, DUR, n3);
    do_release(8'h62);
    wait_until(s);
    check("t3_pending_after_first", int'(pending), 'h22);
    wait_until(n3 + 5);
    check("t3_pending_drained", int'(pending), 0);

    // Low battery at grant doubles duration; later toggles are ignored.
    low_batt = 1'b1;
    do_press(8'h04, x);
    s = x + 4;
    push_play(2, 1'b1, s, 2 * DUR, n1);
    do_release(8'h04);
    wait_until(s + 1000);
    low_batt = 1'b0;
    wait_until(s + 3000);
    low_batt = 1'b1;
    wait_until(s + 4000);
    low_batt = 1'b0;
    check("t4_slow_hold", int'(snd_slow), 1);
    wait_until(n1 + 5);

    // Retrigger own button after tick 200: stop lands at tick 450.
    do_press(8'h10, x);
    s = x + 4;
    t0 = tick_after(s + 3);
    x2 = t0 + 199 * TD + 1;
    stopv = t0 + 449 * TD + 1;
    push_start(4, 1'b0, s);
    push_end(4, 1'b1, stopv);
    n1 = tick_after(stopv) + (GAPT - 1) * TD + 2;
    do_release(8'h10);
    wait_until(x2);
    btn[4] = 1'b1;
    do_release(8'h10);
    wait_until(x2 + 8);
    check("t5_pending_own", int'(pending), 0);
    check("t5_active_after_retrig", int'(active), 1);
    wait_until(n1 + 5);

    // Reset mid-PLAY at tick 100.
    do_press(8'h08, x);
    s = x + 4;
    push_start(3, 1'b0, s);
    do_release(8'h08);
    t0 = tick_after(s + 3);
    wait_until(t0 + 99 * TD + 2);
    check("t6_active_before_rst", int'(active), 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_active", int'(active), 0);
    check("t6_rst_start", int'(snd_start), 0);
    check("t6_rst_stop", int'(snd_stop), 0);
    check("t6_rst_id", int'(snd_id), 0);
    check("t6_rst_pending", int'(pending), 0);
    repeat (3) @(negedge clk);
    check("t6_rst_stop_hold", int'(snd_stop), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    do_press(8'h21, x);
    s2 = x + 4;
    push_play(0, 1'b0, s2, DUR, n1);
    push_play(5, 1'b0, n1, DUR, n2);
    do_release(8'h21);
    wait_until(n2 + 5);
    check("t6_pending_drained", int'(pending), 0);

    check("events_outstanding", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snd_voice_sched.md
SND_VOICE_SCHED -- requirements
Module: snd_voice_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of button requesters.
REQ-002 SHALL have parameter TICK_DIV, default 50000, clk cycles per 1 ms tick at 50 MHz.
REQ-003 SHALL have parameter DUR_MS, default 250, play duration in ticks.
REQ-004 SHALL have parameter GAP_MS, default 20, silent gap in ticks between sounds.
REQ-005 SHALL have parameter ACK_TMO, default 16, max clk cycles to wait for engine busy after start.
REQ-006 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port btn  input  N_REQ  raw asynchronous button levels, active-high.
REQ-009 SHALL have port low_batt  input  1  low-battery mode level.
REQ-010 SHALL have port snd_busy  input  1  sound engine is producing a sound.
REQ-011 SHALL have port snd_start  output  1  one-cycle pulse starting the engine.
REQ-012 SHALL have port snd_stop  output  1  one-cycle pulse stopping the engine.
REQ-013 SHALL have port snd_id  output  clog2(N_REQ)  sound index, held stable from snd_start until the next snd_start.
REQ-014 SHALL have port snd_slow  output  1  registered copy of low_batt, sampled at grant.
REQ-015 SHALL have port pending  output  N_REQ  latched unserviced requests.
REQ-016 SHALL have port active  output  1  high in states START and PLAY.

Function
REQ-017 SHALL pass btn through a 2-flop synchronizer, then detect rising edges one cycle later.
REQ-018 SHALL set pending[i] on a rising edge of btn[i]; repeated edges while already pending SHALL not queue a second request.
REQ-019 SHALL clear pending[i] in the cycle it is granted; an edge on the same bit in that cycle SHALL be merged, leaving the bit 0.
REQ-020 SHALL generate a 1 ms tick strobe from a free-running counter, 0..TICK_DIV-1, wrapping to 0.
REQ-021 SHALL implement FSM states IDLE, START, PLAY, GAP.
REQ-022 IDLE: if pending is non-zero, SHALL grant by round-robin starting at last_id+1 modulo N_REQ, load snd_id, then go to START.
REQ-023 START: SHALL pulse snd_start for the first cycle only, then wait for snd_busy=1 and go to PLAY; after ACK_TMO cycles without busy, SHALL go to GAP.
REQ-024 PLAY: SHALL count ticks up to DUR_MS, or 2*DUR_MS when snd_slow=1; on expiry SHALL pulse snd_stop and go to GAP.
REQ-025 PLAY: if snd_busy falls before expiry, SHALL go to GAP without snd_stop.
REQ-026 PLAY: a rising edge on btn[snd_id] SHALL restart the duration counter at 0 and SHALL NOT set pending.
REQ-027 GAP: SHALL count GAP_MS ticks, then go to IDLE.
REQ-028 Grant-to-snd_start latency SHALL be exactly 1 clk.
REQ-029 A low_batt change during PLAY SHALL NOT affect the current sound.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset_n=0: state=IDLE; pending=0; snd_start=0; snd_stop=0; snd_id=0; snd_slow=0; active=0; synchronizers, tick counter and duration counter=0; last_id=N_REQ-1 so that the first grant checks index 0 first.
REQ-032 Reset asserted mid-PLAY SHALL drop all outputs immediately and SHALL NOT emit snd_stop.

Structure
REQ-033 Shared package snd_pkg SHALL hold the state enum and the default constants for TICK_DIV, DUR_MS, GAP_MS and ACK_TMO.
REQ-034 The round-robin grant SHALL be a sub-module rr_arbiter with ports req, last, grant_valid and grant_id.

Verification (TICK_DIV=10 for speed)
REQ-035 btn[3] rising, engine raises busy 2 cycles after snd_start -> snd_start pulse with snd_id=3, PLAY for 250 ticks, snd_stop, 20-tick GAP, then IDLE.
REQ-036 btn[1], btn[5] and btn[6] rising in the same cycle, last_id=5 -> grants in order 6, 1, 5; pending reaches 0.
REQ-037 low_batt=1 at grant of id 2 -> snd_slow=1, snd_stop after 500 ticks; toggling low_batt mid-PLAY does not change this.
REQ-038 snd_busy never rises -> GAP entered 16 cycles after snd_start, no snd_stop.
REQ-039 btn[4] re-pressed at tick 200 of its own PLAY -> snd_stop at tick 450 from the original start; pending[4] stays 0.
REQ-040 reset_n pulled low at tick 100 of PLAY -> all outputs 0 in the same cycle, no snd_stop; after release, first grant checks index 0 first.
